// File: rtl/vmem_fill_if.sv
// Bus bundle between a fill-engine client and vmem_fill_engine.
//   master : drives fill requests (start/abort/rectangle/color) and the host
//            byte-write port; observes status and the framebuffer write port.
//   slave  : the fill engine itself.
// Signals:
//   start, abort            fill request / cancel
//   x0, y0, w, h            rectangle origin and size in pixels
//   color                   RGB332 fill value
//   host_wr/addr/data       host byte write, passed through with priority
//   busy, done, clipped     engine status
//   cpu_wr/addr/data        registered framebuffer byte-write port
interface vmem_fill_if;
    logic        start;
    logic        abort;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [7:0]  color;
    logic        host_wr;
    logic [31:0] host_addr;
    logic [7:0]  host_data;
    logic        busy;
    logic        done;
    logic        clipped;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;

    modport master (
        output start, abort, x0, y0, w, h, color, host_wr, host_addr, host_data,
        input  busy, done, clipped, cpu_wr, cpu_addr, cpu_data
    );

    modport slave (
        input  start, abort, x0, y0, w, h, color, host_wr, host_addr, host_data,
        output busy, done, clipped, cpu_wr, cpu_addr, cpu_data
    );
endinterface

// File: rtl/vmem_fill_engine.sv
// Rectangle fill engine in front of the H_RES x V_RES byte-per-pixel
// framebuffer. Writes one RGB332 pixel per clock, in raster order, into the
// rectangle clipped to the screen. Host byte writes pass straight through to
// the framebuffer port with priority and stall the engine for that cycle.
// Ports:
//   cpu_clk  clock shared with the framebuffer write port
//   reset    asynchronous, active-high
//   bus      vmem_fill_if.slave: request/rectangle/color inputs, host write
//            port, busy/done/clipped status, registered cpu_wr/addr/data
module vmem_fill_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 400
) (
    input  logic       cpu_clk,
    input  logic       reset,
    vmem_fill_if.slave bus
);
    // Framebuffer addresses never reach H_RES*V_RES, so this width holds them all.
    localparam int              AW     = $clog2(H_RES * V_RES);
    localparam logic [AW-1:0]   STRIDE = AW'(H_RES);
    localparam logic [10:0]     H_LIM  = 11'(H_RES);
    localparam logic [10:0]     V_LIM  = 11'(V_RES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // Request captured on the accepted start edge.
    logic [9:0]    x0_q;
    logic [9:0]    y0_q;
    logic [9:0]    w_q;
    logic [9:0]    h_q;
    logic [7:0]    color_q;

    // Walk state for the clipped rectangle.
    logic [10:0]   ew_m1_q;
    logic [10:0]   eh_m1_q;
    logic [10:0]   col_q;
    logic [10:0]   row_q;
    logic [AW-1:0] row_base_q;

    logic          clipped_q;
    logic          cpu_wr_q;
    logic [31:0]   cpu_addr_q;
    logic [7:0]    cpu_data_q;

    // Clip arithmetic, evaluated from the latched request during SETUP.
    logic [10:0]   x0_e;
    logic [10:0]   y0_e;
    logic [10:0]   w_e;
    logic [10:0]   h_e;
    logic [10:0]   room_x;
    logic [10:0]   room_y;
    logic [10:0]   ew;
    logic [10:0]   eh;
    logic          invalid;
    logic          clip_now;
    logic [AW-1:0] base;

    logic          accept;
    logic          issue;
    logic          last_pix;
    logic [AW-1:0] pix_addr;

    assign accept   = (state_q == IDLE) && bus.start;
    assign pix_addr = row_base_q + AW'(col_q);

    always_comb begin
        x0_e    = {1'b0, x0_q};
        y0_e    = {1'b0, y0_q};
        w_e     = {1'b0, w_q};
        h_e     = {1'b0, h_q};
        invalid = (x0_e >= H_LIM) | (y0_e >= V_LIM) | (w_e == 11'd0) | (h_e == 11'd0);
        // room_* is only meaningful when the origin is on screen; an
        // off-screen origin is already flagged invalid and forces ew/eh to 0.
        room_x  = H_LIM - x0_e;
        room_y  = V_LIM - y0_e;
        ew      = (w_e < room_x) ? w_e : room_x;
        eh      = (h_e < room_y) ? h_e : room_y;
        if (invalid) begin
            ew = 11'd0;
            eh = 11'd0;
        end
        clip_now = invalid | (ew != w_e) | (eh != h_e);
        base     = AW'(y0_q) * STRIDE + AW'(x0_q);
    end

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        last_pix = (row_q == eh_m1_q) && (col_q == ew_m1_q);
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = SETUP;
            end
            SETUP: begin
                if (bus.abort)    state_d = IDLE;
                else if (invalid) state_d = DONE;
                else              state_d = FILL;
            end
            FILL: begin
                // A host write owns the output register this cycle, so the
                // engine simply holds its position and retries next cycle.
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!bus.host_wr) begin
                    issue = 1'b1;
                    if (last_pix) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge cpu_clk) begin
        if (accept) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            w_q     <= bus.w;
            h_q     <= bus.h;
            color_q <= bus.color;
        end
    end

    // Row base is kept as a running sum so no multiply sits in the fill path.
    always_ff @(posedge cpu_clk) begin
        if (state_q == SETUP) begin
            row_base_q <= base;
            col_q      <= 11'd0;
            row_q      <= 11'd0;
            ew_m1_q    <= ew - 11'd1;
            eh_m1_q    <= eh - 11'd1;
        end else if (issue) begin
            if (col_q == ew_m1_q) begin
                col_q      <= 11'd0;
                row_q      <= row_q + 11'd1;
                row_base_q <= row_base_q + STRIDE;
            end else begin
                col_q      <= col_q + 11'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            clipped_q <= 1'b0;
        end else if (accept) begin
            clipped_q <= 1'b0;
        end else if (state_q == SETUP) begin
            clipped_q <= clip_now;
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            cpu_wr_q   <= 1'b0;
            cpu_addr_q <= 32'd0;
            cpu_data_q <= 8'd0;
        end else if (bus.host_wr) begin
            cpu_wr_q   <= 1'b1;
            cpu_addr_q <= bus.host_addr;
            cpu_data_q <= bus.host_data;
        end else if (issue) begin
            cpu_wr_q   <= 1'b1;
            cpu_addr_q <= 32'(pix_addr);
            cpu_data_q <= color_q;
        end else begin
            cpu_wr_q   <= 1'b0;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.clipped  = clipped_q;
    assign bus.cpu_wr   = cpu_wr_q;
    assign bus.cpu_addr = cpu_addr_q;
    assign bus.cpu_data = cpu_data_q;
endmodule

// File: tb/tb_vmem_fill_engine.sv
// Testbench for vmem_fill_engine: table vectors, hand-written corner
// sequences, and randomized fills with random host writes.
module tb_vmem_fill_engine;
    localparam int H_RES = 640;
    localparam int V_RES = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vmem_fill_if bus ();

    vmem_fill_engine #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .cpu_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_wr, s_busy, s_done, s_clip;
    logic [31:0] s_addr;
    logic [7:0]  s_data;
    logic [9:0]  r_x0, r_y0, r_w, r_h;
    logic [7:0]  r_col;

    typedef struct {
        int         x0, y0, w, h;
        logic [7:0] col;
        int         n;
        int         first;
        int         last;
        int         lat;
        logic       clip;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after the rising edge, sample outputs on the falling edge.
    task automatic do_cycle(input logic st, input logic ab, input logic hw,
                            input logic [31:0] ha, input logic [7:0] hd);
        @(posedge clk);
        #1;
        bus.start     = st;
        bus.abort     = ab;
        bus.host_wr   = hw;
        bus.host_addr = ha;
        bus.host_data = hd;
        bus.x0        = r_x0;
        bus.y0        = r_y0;
        bus.w         = r_w;
        bus.h         = r_h;
        bus.color     = r_col;
        @(negedge clk);
        s_wr   = bus.cpu_wr;
        s_addr = bus.cpu_addr;
        s_data = bus.cpu_data;
        s_busy = bus.busy;
        s_done = bus.done;
        s_clip = bus.clipped;
    endtask

    function automatic void pick_host(input int mode, input int off, input int t,
                                      output logic hw, output logic [31:0] ha,
                                      output logic [7:0] hd);
        hw = 1'b0;
        ha = 32'd0;
        hd = 8'd0;
        if (mode == 1) begin
            hw = ($urandom_range(0, 3) == 0);
            ha = $urandom;
            hd = 8'($urandom);
        end else if (mode == 2) begin
            hw = (t == off);
            ha = 32'd100;
            hd = 8'h5A;
        end
    endfunction

    // Reference: the clipped rectangle is enumerated as a raster list of
    // addresses; each cycle from start+2 without a host write consumes the next
    // one, which then shows on the output a cycle later.
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic [7:0] col, input int host_mode, input int host_off,
                            input int restart_off, output int n_eng, output int first_a,
                            output int last_a, output int lat, output logic clip_seen);
        int          ew, eh, nn, k, done_at, limit;
        bit          invalid, exp_clip, finished;
        int          pix[$];
        logic        hw, prev_hw, eng_prev, exp_wr;
        logic [31:0] ha, prev_ha, eng_addr;
        logic [7:0]  hd, prev_hd;

        invalid  = (x0 >= H_RES) || (y0 >= V_RES) || (w == 0) || (h == 0);
        ew       = invalid ? 0 : ((w < H_RES - x0) ? w : H_RES - x0);
        eh       = invalid ? 0 : ((h < V_RES - y0) ? h : V_RES - y0);
        exp_clip = invalid || (ew != w) || (eh != h);
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                pix.push_back((y0 + r) * H_RES + x0 + c);
        nn        = pix.size();
        done_at   = (nn == 0) ? 2 : -1;
        k         = 0;
        n_eng     = 0;
        first_a   = -1;
        last_a    = -1;
        lat       = -1;
        clip_seen = 1'b0;
        finished  = 1'b0;
        limit     = 3 * nn + 20;
        eng_addr  = 32'd0;

        r_x0  = 10'(x0);
        r_y0  = 10'(y0);
        r_w   = 10'(w);
        r_h   = 10'(h);
        r_col = col;
        pick_host(host_mode, host_off, 0, hw, ha, hd);
        do_cycle(1'b1, 1'b0, hw, ha, hd);
        prev_hw  = hw;
        prev_ha  = ha;
        prev_hd  = hd;
        eng_prev = 1'b0;

        for (int t = 1; t <= limit && !finished; t++) begin
            r_x0  = 10'($urandom);
            r_y0  = 10'($urandom);
            r_w   = 10'($urandom);
            r_h   = 10'($urandom);
            r_col = 8'($urandom);
            pick_host(host_mode, host_off, t, hw, ha, hd);
            do_cycle(t == restart_off, 1'b0, hw, ha, hd);

            exp_wr = prev_hw | eng_prev;
            chk("cpu_wr", s_wr, exp_wr);
            if (prev_hw) begin
                chk("host_addr", s_addr, prev_ha);
                chk("host_data", s_data, prev_hd);
            end else if (eng_prev) begin
                chk("pix_addr", s_addr, eng_addr);
                chk("pix_data", s_data, col);
            end
            if (!prev_hw && s_wr) begin
                n_eng++;
                if (first_a < 0) first_a = int'(s_addr);
                last_a = int'(s_addr);
            end
            chk("done", s_done, (t == done_at));
            chk("busy", s_busy, (done_at < 0) || (t <= done_at));
            if (s_done && lat < 0) begin
                lat       = t;
                clip_seen = s_clip;
            end
            if (t == done_at) chk("clipped", s_clip, exp_clip);

            eng_prev = (t >= 2) && (k < nn) && !hw;
            if (eng_prev) begin
                eng_addr = 32'(pix[k]);
                k++;
                if (k == nn) done_at = t + 1;
            end
            prev_hw = hw;
            prev_ha = ha;
            prev_hd = hd;
            if (done_at >= 0 && t == done_at + 1) finished = 1'b1;
        end
        if (!finished) chk("fill_timeout", 0, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_eng, first_a, last_a, lat, wcount;
        logic        clip_seen, done_seen;

        vecs[0] = '{0,   0,   2,   2,   8'hE0, 4,   0,      641,    6,   1'b0};
        vecs[1] = '{638, 399, 10,  5,   8'h1C, 2,   255998, 255999, 4,   1'b1};
        vecs[2] = '{5,   5,   0,   3,   8'hFF, 0,   0,      0,      2,   1'b1};
        vecs[3] = '{640, 0,   4,   4,   8'hAA, 0,   0,      0,      2,   1'b1};
        vecs[4] = '{0,   400, 1,   1,   8'h11, 0,   0,      0,      2,   1'b1};
        vecs[5] = '{10,  20,  3,   1,   8'h55, 3,   12810,  12812,  5,   1'b0};
        vecs[6] = '{639, 0,   1,   1,   8'h77, 1,   639,    639,    3,   1'b0};
        vecs[7] = '{600, 390, 100, 100, 8'h3C, 400, 250200, 255999, 402, 1'b1};
        vecs[8] = '{0,   0,   640, 1,   8'hC3, 640, 0,      639,    642, 1'b0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.host_wr   = 1'b0;
        bus.host_addr = 32'd0;
        bus.host_data = 8'd0;
        bus.x0        = 10'd0;
        bus.y0        = 10'd0;
        bus.w         = 10'd0;
        bus.h         = 10'd0;
        bus.color     = 8'd0;
        r_x0 = 10'd0; r_y0 = 10'd0; r_w = 10'd0; r_h = 10'd0; r_col = 8'd0;
        #12;
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_clip",  bus.clipped, 0);
        chk("rst_wr",    bus.cpu_wr, 0);
        chk("rst_addr",  bus.cpu_addr, 0);
        chk("rst_data",  bus.cpu_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, no host traffic.
        for (int i = 0; i < 9; i++) begin
            run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].col,
                     0, 0, -1, n_eng, first_a, last_a, lat, clip_seen);
            chk($sformatf("vec%0d_count", i), n_eng, vecs[i].n);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_clipped", i), clip_seen, vecs[i].clip);
            if (vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first", i), first_a, vecs[i].first);
                chk($sformatf("vec%0d_last", i), last_a, vecs[i].last);
            end
        end

        // 4x1 fill with a host write in the second fill cycle.
        run_fill(0, 0, 4, 1, 8'h42, 2, 3, -1, n_eng, first_a, last_a, lat, clip_seen);
        chk("stall_count", n_eng, 4);
        chk("stall_latency", lat, 7);

        // Large clear with a start pulse mid-fill that must be ignored.
        run_fill(0, 0, 640, 40, 8'h00, 0, 0, 100, n_eng, first_a, last_a, lat, clip_seen);
        chk("clear_count", n_eng, 25600);
        chk("clear_first", first_a, 0);
        chk("clear_last", last_a, 25599);
        chk("clear_latency", lat, 25602);

        // Randomized rectangles with random host traffic.
        for (int i = 0; i < 12; i++) begin
            run_fill($urandom_range(0, 700), $urandom_range(0, 450), $urandom_range(0, 50),
                     $urandom_range(0, 12), 8'($urandom), 1, 0, $urandom_range(3, 30),
                     n_eng, first_a, last_a, lat, clip_seen);
        end

        // Abort after 10 pixels.
        r_x0 = 10'd0; r_y0 = 10'd0; r_w = 10'd20; r_h = 10'd20; r_col = 8'h99;
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        wcount    = 0;
        done_seen = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            do_cycle(1'b0, (t == 12), 1'b0, 32'd0, 8'd0);
            if (s_wr) wcount++;
            if (s_done) done_seen = 1'b1;
            if (t == 12) chk("abort_busy_at_abort", s_busy, 1);
            if (t == 13) chk("abort_busy_after", s_busy, 0);
        end
        chk("abort_writes_10_or_11", (wcount >= 10 && wcount <= 11), 1);
        chk("abort_no_done", done_seen, 0);

        // Asynchronous reset in the middle of a fill.
        r_x0 = 10'd0; r_y0 = 10'd0; r_w = 10'd8; r_h = 10'd8; r_col = 8'h33;
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        for (int t = 1; t <= 6; t++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        chk("pre_reset_wr", s_wr, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("areset_busy", bus.busy, 0);
        chk("areset_done", bus.done, 0);
        chk("areset_clip", bus.clipped, 0);
        chk("areset_wr",   bus.cpu_wr, 0);
        chk("areset_addr", bus.cpu_addr, 0);
        chk("areset_data", bus.cpu_data, 0);
        @(negedge clk);
        rst = 1'b0;
        run_fill(0, 0, 2, 2, 8'hE0, 0, 0, -1, n_eng, first_a, last_a, lat, clip_seen);
        chk("post_reset_count", n_eng, 4);
        chk("post_reset_latency", lat, 6);
        chk("post_reset_last", last_a, 641);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
